// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the bridge's requester side and the register-file completer.
interface apb_slave_regfile_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32
);
  logic                   pselx;
  logic                   penable;
  logic                   pwrite;
  logic [ADDRWIDTH-1:0]   paddr;
  logic [DATAWIDTH-1:0]   pwdata;
  logic [DATAWIDTH/8-1:0] pstrb;
  logic [2:0]             pprot;
  logic [DATAWIDTH-1:0]   prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of byte-strobed registers, programmable wait states and error responses.
// Register 0 is a read-only ID; the last register is writable only by privileged accesses.
module apb_slave_regfile #(
  parameter int                        DATAWIDTH   = 32,
  parameter int                        ADDRWIDTH   = 32,
  parameter int                        NUM_REGS    = 16,
  parameter int                        WAIT_STATES = 1,
  parameter logic [DATAWIDTH-1:0]      ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                          pclk,
  input  logic                          preset,
  apb_slave_regfile_if.slave            apb,
  output logic [NUM_REGS*DATAWIDTH-1:0] regs_o
);

  localparam int         NBYTES = DATAWIDTH / 8;
  localparam int         OFFW   = $clog2(NBYTES);
  localparam int         IDXW   = $clog2(NUM_REGS);
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_cnt;
  logic [DATAWIDTH-1:0] r_regs [NUM_REGS];

  logic [IDXW-1:0]      w_index;
  logic                 w_misaligned;
  logic                 w_out_of_range;
  logic                 w_err;
  logic                 w_done;
  logic [DATAWIDTH-1:0] w_rdval;
  logic                 w_unused;

  // penable is deliberately ignored: a strobe seen in IDLE is treated as a setup phase.
  assign w_unused       = ^{apb.penable, apb.pprot[2:1]};
  assign w_index        = apb.paddr[OFFW +: IDXW];
  assign w_misaligned   = |apb.paddr[OFFW-1:0];
  assign w_out_of_range = |apb.paddr[ADDRWIDTH-1:OFFW+IDXW];
  assign w_rdval        = (w_index == IDXW'(0)) ? ID_VALUE : r_regs[w_index];

  // Error classification in priority order.
  always_comb begin
    w_err = 1'b0;
    if (w_misaligned) begin
      w_err = 1'b1;
    end else if (w_out_of_range) begin
      w_err = 1'b1;
    end else if (apb.pwrite && (w_index == IDXW'(0))) begin
      w_err = 1'b1;
    end else if (apb.pwrite && (w_index == IDXW'(NUM_REGS - 1)) && !apb.pprot[0]) begin
      w_err = 1'b1;
    end else begin
      w_err = 1'b0;
    end
  end

  // Next-state logic and transfer-completion strobe.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (apb.pselx) begin
          w_next_state = S_ACCESS;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (!apb.pselx) begin
          w_next_state = S_IDLE;
        end else if (r_cnt == WS_CNT) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = S_ACCESS;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Bus response: data and error only appear in the completing cycle.
  always_comb begin
    apb.pready  = w_done;
    apb.pslverr = w_done & w_err;
    if (w_done && !apb.pwrite && !w_err) begin
      apb.prdata = w_rdval;
    end else begin
      apb.prdata = '0;
    end
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Wait-state counter: cleared in IDLE, counts up while the access is held.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= 4'd0;
    end else if (apb.pselx && (r_cnt != WS_CNT)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Register bank with byte-lane write enables.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_done && apb.pwrite && !w_err) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (apb.pstrb[k]) begin
          r_regs[w_index][k*8 +: 8] <= apb.pwdata[k*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    if (g == 0) begin : g_id
      assign regs_o[g*DATAWIDTH +: DATAWIDTH] = ID_VALUE;
    end else begin : g_rw
      assign regs_o[g*DATAWIDTH +: DATAWIDTH] = r_regs[g];
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with one wait state, one zero-wait instance.
module tb_apb_slave_regfile;

  logic        pclk;
  logic        preset;
  logic        sel0, sel1;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [511:0] regs1, regs0;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_slave_regfile_if #(.DATAWIDTH(32), .ADDRWIDTH(32)) if1 ();
  apb_slave_regfile_if #(.DATAWIDTH(32), .ADDRWIDTH(32)) if0 ();

  assign if1.pselx = sel1;   assign if0.pselx = sel0;
  assign if1.penable = penable; assign if0.penable = penable;
  assign if1.pwrite = pwrite;   assign if0.pwrite = pwrite;
  assign if1.paddr = paddr;     assign if0.paddr = paddr;
  assign if1.pwdata = pwdata;   assign if0.pwdata = pwdata;
  assign if1.pstrb = pstrb;     assign if0.pstrb = pstrb;
  assign if1.pprot = pprot;     assign if0.pprot = pprot;

  apb_slave_regfile #(.WAIT_STATES(1)) u_dut1 (
    .pclk(pclk), .preset(preset), .apb(if1.slave), .regs_o(regs1)
  );
  apb_slave_regfile #(.WAIT_STATES(0)) u_dut0 (
    .pclk(pclk), .preset(preset), .apb(if0.slave), .regs_o(regs0)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the completing edge with select still held.
  task automatic xfer(input bit which, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rd, output logic err, output int cycles);
    int w;
    if (which) sel1 = 1'b1; else sel0 = 1'b1;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    cycles = 2;
    w = 0;
    while (((which ? if1.pready : if0.pready) !== 1'b1) && (w < 20)) begin
      @(negedge pclk);
      w++;
      cycles++;
    end
    check("xfer_timeout", 64'(w < 20), 64'd1);
    rd  = which ? if1.prdata  : if0.prdata;
    err = which ? if1.pslverr : if0.pslverr;
    @(negedge pclk);
    penable = 1'b0;
  endtask

  task automatic idle();
    sel0 = 1'b0; sel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cyc;

    preset = 1'b1; sel0 = 1'b0; sel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
    repeat (3) @(negedge pclk);
    check("rst_pready",  64'(if1.pready),  64'd0);
    check("rst_pslverr", 64'(if1.pslverr), 64'd0);
    check("rst_prdata",  64'(if1.prdata),  64'd0);
    check("rst_reg1",    64'(regs1[63:32]), 64'd0);
    preset = 1'b0;
    @(negedge pclk);

    // 1: ID read, one wait state, three cycles total
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("id_rdata", 64'(rd), 64'hA9B0_0001);
    check("id_err",   64'(err), 64'd0);
    check("id_cycles", 64'(cyc), 64'd3);
    idle();

    // 2: strobed write then readback
    xfer(1'b1, 1'b1, 32'h4, 32'h1122_3344, 4'b0101, 3'b000, rd, err, cyc);
    check("wr4_err", 64'(err), 64'd0);
    check("wr4_regs_o", 64'(regs1[63:32]), 64'h0022_0044);
    idle();
    xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 3'b000, rd, err, cyc);
    check("rd4", 64'(rd), 64'h0022_0044);
    idle();

    // 3: zero-strobe no-op, write to ID register
    xfer(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 3'b000, rd, err, cyc);
    check("wr8_nostrb_err", 64'(err), 64'd0);
    idle();
    xfer(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("rd8_unchanged", 64'(rd), 64'd0);
    idle();
    xfer(1'b1, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 3'b001, rd, err, cyc);
    check("wr0_err", 64'(err), 64'd1);
    idle();
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("rd0_after_wr", 64'(rd), 64'hA9B0_0001);
    idle();

    // 4: error cases
    xfer(1'b1, 1'b0, 32'h2, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("misalign_err", 64'(err), 64'd1);
    check("misalign_rd",  64'(rd),  64'd0);
    idle();
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("oor_err", 64'(err), 64'd1);
    check("oor_rd",  64'(rd),  64'd0);
    idle();
    xfer(1'b1, 1'b1, 32'h3C, 32'hDEAD_0001, 4'hF, 3'b000, rd, err, cyc);
    check("ctrl_unpriv_err", 64'(err), 64'd1);
    check("ctrl_unpriv_reg", 64'(regs1[511:480]), 64'd0);
    idle();
    xfer(1'b1, 1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 3'b001, rd, err, cyc);
    check("ctrl_priv_err", 64'(err), 64'd0);
    idle();
    xfer(1'b1, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("ctrl_priv_rd", 64'(rd), 64'hCAFE_F00D);
    idle();

    // 5a: master drops select during the wait cycle
    sel1 = 1'b1; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    pprot = 3'b001; penable = 1'b0;
    @(negedge pclk);
    check("abort_wait_pready", 64'(if1.pready), 64'd0);
    sel1 = 1'b0;
    check("abort_drop_pready", 64'(if1.pready), 64'd0);
    @(negedge pclk);
    check("abort_after_pready", 64'(if1.pready), 64'd0);
    check("abort_regs_o", 64'(regs1[127:96]), 64'd0);
    xfer(1'b1, 1'b0, 32'hC, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("abort_rd", 64'(rd), 64'd0);
    idle();

    // 5b: reset lands on the completing cycle of a write
    xfer(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, err, cyc);
    idle();
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("pre_rst_rd10", 64'(rd), 64'hDEAD_BEEF);
    idle();
    sel1 = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1357_9BDF; pstrb = 4'hF;
    pprot = 3'b000; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check("rst_mid_pready_before", 64'(if1.pready), 64'd1);
    preset = 1'b1;
    @(negedge pclk);
    check("rst_mid_pready",  64'(if1.pready),  64'd0);
    check("rst_mid_pslverr", 64'(if1.pslverr), 64'd0);
    check("rst_mid_prdata",  64'(if1.prdata),  64'd0);
    preset = 1'b0; sel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("rst_mid_rd10", 64'(rd), 64'd0);
    idle();
    xfer(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("rst_cleared_rd4", 64'(rd), 64'd0);
    idle();

    // 6: zero-wait instance, back-to-back writes
    xfer(1'b0, 1'b1, 32'h4, 32'hAAAA_0004, 4'hF, 3'b000, rd, err, cyc);
    check("b2b_wr4_cycles", 64'(cyc), 64'd2);
    check("b2b_wr4_err", 64'(err), 64'd0);
    xfer(1'b0, 1'b1, 32'h8, 32'hBBBB_0008, 4'hF, 3'b000, rd, err, cyc);
    check("b2b_wr8_cycles", 64'(cyc), 64'd2);
    xfer(1'b0, 1'b1, 32'hC, 32'hCCCC_000C, 4'hF, 3'b000, rd, err, cyc);
    check("b2b_wrC_cycles", 64'(cyc), 64'd2);
    xfer(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("b2b_rd8", 64'(rd), 64'hBBBB_0008);
    idle();
    check("b2b_reg1", 64'(regs0[63:32]),  64'hAAAA_0004);
    check("b2b_reg2", 64'(regs0[95:64]),  64'hBBBB_0008);
    check("b2b_reg3", 64'(regs0[127:96]), 64'hCCCC_000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
